// File: rtl/fetch_prefetch_buffer.sv
// Wishbone instruction prefetch FIFO; head visible 1 cycle after ack, stall_i holds head, fetch throttles at DEPTH entries.
// Optional PREFETCH_FAULT_EN: bus errors become fault entries (fault_o) and fetch halts until the next redirect.
module fetch_prefetch_buffer #(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
    parameter int          DEPTH      = 4,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] br_j_addr_i,
    input  logic [31:0] exc_ret_addr_i,
    input  logic [1:0]  sel_addr_i,
    input  logic        stall_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [31:0] wbm_addr_o
`ifdef PREFETCH_FAULT_EN
    ,
    output logic        fault_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } state_e;

    state_e          state_q;
    logic            cyc_q;
    logic [31:0]     addr_q;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     fetch_pc_d;
    logic            discard_q;

    logic [31:0]     pc_mem  [DEPTH];
    logic [31:0]     dat_mem [DEPTH];
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    logic            redirect;
    logic [31:0]     target;
    logic            resp;
    logic            push;
    logic            pop;
    logic            issue;
    logic            fetch_stop;
    logic [31:0]     push_dat;

    always_comb begin
        redirect = |sel_addr_i;
        target   = sel_addr_i[1] ? exc_ret_addr_i : br_j_addr_i;
        resp     = (state_q == ST_REQ) && (wbm_ack_i || wbm_err_i);
        // A redirect kills both the in-flight response and the head pop.
        push     = resp && !discard_q && !redirect;
        pop      = valid_o && !stall_i && !redirect;
        push_dat = wbm_err_i ? NOP_INST : wbm_dat_i;
        issue    = (state_q == ST_IDLE) && !redirect && !fetch_stop
                   && (count_q < CW'(DEPTH));
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = {target[31:2], 2'b00};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_comb begin
        count_d = count_q;
        if (redirect) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cyc_q      <= 1'b0;
            addr_q     <= '0;
            fetch_pc_q <= RESET_ADDR;
            discard_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        state_q <= ST_REQ;
                        cyc_q   <= 1'b1;
                        addr_q  <= {fetch_pc_q[31:2], 2'b00};
                    end
                end
                ST_REQ: begin
                    if (resp) begin
                        state_q   <= ST_IDLE;
                        cyc_q     <= 1'b0;
                        discard_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cyc_q   <= 1'b0;
                end
            endcase
            fetch_pc_q <= fetch_pc_d;
            // Bus cycle must still complete; remember to drop whatever comes back.
            if (redirect && (state_q == ST_REQ) && !resp) begin
                discard_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (redirect) begin
                rd_ptr_q <= wr_ptr_q;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= fetch_pc_q;
            dat_mem[wr_ptr_q] <= push_dat;
        end
    end

`ifdef PREFETCH_FAULT_EN
    logic             stop_q;
    logic [DEPTH-1:0] flt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stop_q <= 1'b0;
            flt_q  <= '0;
        end else begin
            if (redirect) begin
                stop_q <= 1'b0;
            end else if (push && wbm_err_i) begin
                stop_q <= 1'b1;
            end
            if (push) begin
                flt_q[wr_ptr_q] <= wbm_err_i;
            end
        end
    end

    assign fetch_stop = stop_q;
    assign fault_o    = valid_o && flt_q[rd_ptr_q];
`else
    assign fetch_stop = 1'b0;
`endif

    assign valid_o       = (count_q != '0);
    assign instruction_o = valid_o ? dat_mem[rd_ptr_q] : NOP_INST;
    assign pc_o          = valid_o ? pc_mem[rd_ptr_q] : 32'd0;
    assign wbm_cyc_o     = cyc_q;
    assign wbm_stb_o     = cyc_q;
    assign wbm_addr_o    = addr_q;

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer with an auto-acking Wishbone responder.
module tb_fetch_prefetch_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] br_j_addr_i;
    logic [31:0] exc_ret_addr_i;
    logic [1:0]  sel_addr_i;
    logic        stall_i;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [31:0] wbm_addr_o;
`ifdef PREFETCH_FAULT_EN
    logic        fault_o;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        flt;
    } pop_t;

    int          errors = 0;
    int          checks = 0;
    int          resp_wait;
    int          cnt;
    logic [31:0] resp_err_addr;
    logic        resp_manual;
    logic        man_ack;
    logic        prev_cyc;
    logic [31:0] issue_q [$];
    pop_t        pop_q [$];

    fetch_prefetch_buffer dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .br_j_addr_i    (br_j_addr_i),
        .exc_ret_addr_i (exc_ret_addr_i),
        .sel_addr_i     (sel_addr_i),
        .stall_i        (stall_i),
        .instruction_o  (instruction_o),
        .pc_o           (pc_o),
        .valid_o        (valid_o),
        .wbm_dat_i      (wbm_dat_i),
        .wbm_ack_i      (wbm_ack_i),
        .wbm_err_i      (wbm_err_i),
        .wbm_cyc_o      (wbm_cyc_o),
        .wbm_stb_o      (wbm_stb_o),
        .wbm_addr_o     (wbm_addr_o)
`ifdef PREFETCH_FAULT_EN
        ,
        .fault_o        (fault_o)
`endif
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Responder: data word is ~address; err for resp_err_addr; ack after resp_wait cycles of cyc.
    initial begin
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = '0;
        cnt = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_i) begin
                wbm_ack_i = 1'b0;
                wbm_err_i = 1'b0;
                cnt = 0;
            end else if (resp_manual) begin
                wbm_ack_i = man_ack;
                wbm_err_i = 1'b0;
                wbm_dat_i = 32'hDEAD_BEEF;
                cnt = 0;
            end else if (wbm_ack_i || wbm_err_i) begin
                wbm_ack_i = 1'b0;
                wbm_err_i = 1'b0;
            end else if (wbm_cyc_o) begin
                if (cnt == resp_wait) begin
                    if (wbm_addr_o == resp_err_addr) begin
                        wbm_err_i = 1'b1;
                        wbm_dat_i = 32'h0BAD_0BAD;
                    end else begin
                        wbm_ack_i = 1'b1;
                        wbm_dat_i = ~wbm_addr_o;
                    end
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Monitor: log each new bus request and each consumed head entry.
    initial begin
        prev_cyc = 1'b0;
        forever begin
            @(negedge clk_i);
            if (wbm_cyc_o && !prev_cyc) issue_q.push_back(wbm_addr_o);
            prev_cyc = wbm_cyc_o;
            if (!rst_i && valid_o && !stall_i && sel_addr_i == 2'b00) begin
`ifdef PREFETCH_FAULT_EN
                pop_q.push_back('{pc: pc_o, ins: instruction_o, flt: fault_o});
`else
                pop_q.push_back('{pc: pc_o, ins: instruction_o, flt: 1'b0});
`endif
            end
        end
    end

    task automatic apply_reset(input logic stall_v, input int wait_v);
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        stall_i = stall_v;
        sel_addr_i = 2'b00;
        br_j_addr_i = '0;
        exc_ret_addr_i = '0;
        resp_manual = 1'b0;
        man_ack = 1'b0;
        resp_wait = wait_v;
        resp_err_addr = 32'hFFFF_FFFC;
        repeat (3) begin
            @(posedge clk_i);
            #2;
        end
        issue_q.delete();
        pop_q.delete();
        rst_i = 1'b0;
    endtask

    task automatic do_redirect(input logic [1:0] sel, input logic [31:0] exc, input logic [31:0] brj);
        @(posedge clk_i);
        #2;
        sel_addr_i = sel;
        exc_ret_addr_i = exc;
        br_j_addr_i = brj;
        @(posedge clk_i);
        #2;
        sel_addr_i = 2'b00;
        @(negedge clk_i);
    endtask

    task automatic wait_valid(input logic [31:0] exp_pc, input string name);
        int n = 0;
        while (!valid_o && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (!valid_o) begin
            errors++;
            $display("FAIL %s timeout: valid_o=%b required 1", name, valid_o);
        end else begin
            checks++;
            if (pc_o !== exp_pc) begin
                errors++;
                $display("FAIL %s pc: got %h required %h", name, pc_o, exp_pc);
            end
            checks++;
            if (instruction_o !== ~exp_pc) begin
                errors++;
                $display("FAIL %s instr: got %h required %h", name, instruction_o, ~exp_pc);
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++; if (wbm_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b required 0", wbm_cyc_o); end
        checks++; if (wbm_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b required 0", wbm_stb_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", valid_o); end
        checks++; if (instruction_o !== NOP) begin errors++; $display("FAIL reset_instr: got %h required %h", instruction_o, NOP); end
        checks++; if (pc_o !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h required 0", pc_o); end
    endtask

    task automatic test_sequential_fetch();
        int n;
        logic [31:0] exp;
        apply_reset(1'b0, 1);
        n = 0;
        while (!wbm_cyc_o && n < 20) begin @(negedge clk_i); n++; end
        checks++; if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b1) begin errors++; $display("FAIL first_req: cyc=%b stb=%b required 1/1", wbm_cyc_o, wbm_stb_o); end
        checks++; if (instruction_o !== NOP || valid_o !== 1'b0) begin errors++; $display("FAIL pre_ack_nop: instr=%h valid=%b required %h/0", instruction_o, valid_o, NOP); end
        for (int k = 0; k < 3; k++) begin
            exp = 32'h8000_0000 + 32'(4 * k);
            n = 0;
            while (!wbm_ack_i && n < 20) begin @(negedge clk_i); n++; end
            checks++; if (wbm_addr_o !== exp) begin errors++; $display("FAIL seq_addr%0d: got %h required %h", k, wbm_addr_o, exp); end
            checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL seq_valid_at_ack%0d: got %b required 0", k, valid_o); end
            @(negedge clk_i);
            checks++; if (valid_o !== 1'b1 || pc_o !== exp) begin errors++; $display("FAIL seq_pc%0d: valid=%b pc=%h required 1/%h", k, valid_o, pc_o, exp); end
            checks++; if (instruction_o !== ~exp) begin errors++; $display("FAIL seq_instr%0d: got %h required %h", k, instruction_o, ~exp); end
        end
    endtask

    task automatic test_stall_full();
        int n;
        apply_reset(1'b1, 1);
        repeat (40) @(negedge clk_i);
        checks++; if (issue_q.size() != 4) begin errors++; $display("FAIL full_requests: got %0d required 4", issue_q.size()); end
        checks++; if (wbm_cyc_o !== 1'b0) begin errors++; $display("FAIL full_cyc: got %b required 0", wbm_cyc_o); end
        checks++; if (valid_o !== 1'b1 || pc_o !== 32'h8000_0000) begin errors++; $display("FAIL full_head: valid=%b pc=%h required 1/80000000", valid_o, pc_o); end
        checks++; if (pop_q.size() != 0) begin errors++; $display("FAIL full_no_pop: got %0d required 0", pop_q.size()); end
        @(posedge clk_i);
        #2;
        stall_i = 1'b0;
        n = 0;
        while ((pop_q.size() < 4 || issue_q.size() < 5) && n < 60) begin @(negedge clk_i); n++; end
        checks++;
        if (pop_q.size() < 4 || issue_q.size() < 5) begin
            errors++;
            $display("FAIL drain_timeout: pops=%0d reqs=%0d required >=4/>=5", pop_q.size(), issue_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pop_q[i].pc !== 32'h8000_0000 + 32'(4 * i) || pop_q[i].ins !== ~(32'h8000_0000 + 32'(4 * i))) begin
                    errors++;
                    $display("FAIL drain_pop%0d: pc=%h ins=%h required %h", i, pop_q[i].pc, pop_q[i].ins, 32'h8000_0000 + 32'(4 * i));
                end
            end
            checks++; if (issue_q[4] !== 32'h8000_0010) begin errors++; $display("FAIL resume_addr: got %h required 80000010", issue_q[4]); end
        end
    endtask

    task automatic test_redirect_pending();
        int n;
        apply_reset(1'b0, 3);
        n = 0;
        while (!wbm_cyc_o && n < 20) begin @(negedge clk_i); n++; end
        do_redirect(2'b01, 32'h0, 32'h0000_0100);
        checks++; if (wbm_cyc_o !== 1'b1 || wbm_addr_o !== 32'h8000_0000) begin errors++; $display("FAIL pend_hold: cyc=%b addr=%h required 1/80000000", wbm_cyc_o, wbm_addr_o); end
        wait_valid(32'h0000_0100, "pend_first_valid");
        checks++;
        if (issue_q.size() < 2 || issue_q[1] !== 32'h0000_0100) begin
            errors++;
            $display("FAIL pend_next_addr: reqs=%0d addr=%h required 00000100", issue_q.size(), issue_q.size() > 1 ? issue_q[1] : 32'hx);
        end
    endtask

    task automatic test_redirect_priority();
        apply_reset(1'b0, 1);
        do_redirect(2'b11, 32'h0000_0200, 32'h0000_0300);
        wait_valid(32'h0000_0200, "prio_exc");
        do_redirect(2'b01, 32'h0, 32'h0000_0203);
        wait_valid(32'h0000_0200, "align_203");
    endtask

    task automatic test_redirect_pop_ack();
        int n;
        apply_reset(1'b1, 1);
        n = 0;
        while (issue_q.size() < 2 && n < 30) begin @(negedge clk_i); n++; end
        resp_manual = 1'b1;
        man_ack = 1'b1;
        @(posedge clk_i);
        #2;
        stall_i = 1'b0;
        sel_addr_i = 2'b01;
        br_j_addr_i = 32'h0000_0400;
        checks++; if (valid_o !== 1'b1 || wbm_ack_i !== 1'b1 || wbm_cyc_o !== 1'b1) begin errors++; $display("FAIL collide_setup: valid=%b ack=%b cyc=%b required 1/1/1", valid_o, wbm_ack_i, wbm_cyc_o); end
        @(posedge clk_i);
        #2;
        sel_addr_i = 2'b00;
        man_ack = 1'b0;
        @(negedge clk_i);
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL collide_empty: got %b required 0", valid_o); end
        checks++; if (pc_o !== 32'd0 || instruction_o !== NOP) begin errors++; $display("FAIL collide_outputs: pc=%h instr=%h required 0/%h", pc_o, instruction_o, NOP); end
        checks++; if (pop_q.size() != 0) begin errors++; $display("FAIL collide_no_pop: got %0d required 0", pop_q.size()); end
        resp_manual = 1'b0;
        wait_valid(32'h0000_0400, "collide_target");
    endtask

    task automatic test_bus_error();
        int n;
        apply_reset(1'b0, 1);
        resp_err_addr = 32'h8000_0008;
`ifdef PREFETCH_FAULT_EN
        n = 0;
        while (pop_q.size() < 3 && n < 60) begin @(negedge clk_i); n++; end
        repeat (20) @(negedge clk_i);
        checks++;
        if (pop_q.size() != 3) begin
            errors++;
            $display("FAIL fault_pops: got %0d required 3", pop_q.size());
        end else begin
            checks++; if (pop_q[2].pc !== 32'h8000_0008 || pop_q[2].flt !== 1'b1) begin errors++; $display("FAIL fault_head: pc=%h flt=%b required 80000008/1", pop_q[2].pc, pop_q[2].flt); end
            checks++; if (pop_q[1].flt !== 1'b0 || pop_q[2].ins !== NOP) begin errors++; $display("FAIL fault_data: flt1=%b ins2=%h required 0/%h", pop_q[1].flt, pop_q[2].ins, NOP); end
        end
        checks++; if (issue_q.size() != 3 || wbm_cyc_o !== 1'b0) begin errors++; $display("FAIL fault_stop: reqs=%0d cyc=%b required 3/0", issue_q.size(), wbm_cyc_o); end
`else
        n = 0;
        while (pop_q.size() < 4 && n < 60) begin @(negedge clk_i); n++; end
        checks++;
        if (pop_q.size() < 4) begin
            errors++;
            $display("FAIL err_pops: got %0d required >=4", pop_q.size());
        end else begin
            checks++; if (pop_q[2].pc !== 32'h8000_0008 || pop_q[2].ins !== NOP) begin errors++; $display("FAIL err_entry: pc=%h ins=%h required 80000008/%h", pop_q[2].pc, pop_q[2].ins, NOP); end
            checks++; if (pop_q[3].pc !== 32'h8000_000C || pop_q[3].ins !== ~32'h8000_000C) begin errors++; $display("FAIL err_continue: pc=%h ins=%h required 8000000c", pop_q[3].pc, pop_q[3].ins); end
            checks++; if (pop_q[1].ins !== ~32'h8000_0004) begin errors++; $display("FAIL err_prev: ins=%h required %h", pop_q[1].ins, ~32'h8000_0004); end
        end
`endif
    endtask

    initial begin
        rst_i = 1'b1;
        stall_i = 1'b0;
        sel_addr_i = 2'b00;
        br_j_addr_i = '0;
        exc_ret_addr_i = '0;
        resp_wait = 1;
        resp_err_addr = 32'hFFFF_FFFC;
        resp_manual = 1'b0;
        man_ack = 1'b0;
        test_reset();
        test_sequential_fetch();
        test_stall_full();
        test_redirect_pending();
        test_redirect_priority();
        test_redirect_pop_ack();
        test_bus_error();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
